// File: rtl/sun2_dvma_arbiter.sv
// sun2_dvma_arbiter: hands bus ownership from the 68010 CPU to one of NREQ DVMA
//   masters with round-robin priority, using the 68000 BR/BG/BGACK handshake.
// Ports: CLK/RESET (sync, active high); REQ_n/BG_n/AS_n asynchronous active-low
//   inputs; BR_n/BGACK_n/GNT_n registered active-low outputs; OWNER/BUSY show the
//   current grant; TMO pulses when a request gives up waiting for BG.
module sun2_dvma_arbiter #(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ_n,
  input  logic            BG_n,
  input  logic            AS_n,
  output logic            BR_n,
  output logic            BGACK_n,
  output logic [NREQ-1:0] GNT_n,
  output logic [2:0]      OWNER,
  output logic            BUSY,
  output logic            TMO
);

  typedef enum logic [2:0] {IDLE, REQUEST, WAIT_BUS, GRANT, RELEASE} state_t;

  // Synchronizer chains hold raw (active-low) values; stage 0 samples the pin.
  logic [NREQ-1:0]        req_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] bg_sync;
  logic [SYNC_STAGES-1:0] as_sync;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) req_sync[i] <= '1;
      bg_sync <= '1;
      as_sync <= '1;
    end else begin
      req_sync[0] <= REQ_n;
      bg_sync[0]  <= BG_n;
      as_sync[0]  <= AS_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        req_sync[i] <= req_sync[i-1];
        bg_sync[i]  <= bg_sync[i-1];
        as_sync[i]  <= as_sync[i-1];
      end
    end
  end

  logic [NREQ-1:0] sreq;
  logic            sbg, sas;
  assign sreq = ~req_sync[SYNC_STAGES-1];
  assign sbg  = ~bg_sync[SYNC_STAGES-1];
  assign sas  = ~as_sync[SYNC_STAGES-1];

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d, w_q, w_d, owner_q, owner_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            br_q, br_d, bgack_q, bgack_d, busy_q, busy_d, tmo_q, tmo_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  // Round-robin winner: rotate the request vector so PTR lands at bit 0, take
  // the lowest set bit, then add PTR back modulo NREQ.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [2:0]        off;
  logic [3:0]        sum4;
  logic [2:0]        win;

  always_comb begin
    req_dbl = {sreq, sreq} >> ptr_q;
    req_rot = req_dbl[NREQ-1:0];
    off     = 3'd0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_rot[i]) off = 3'(i);
    end
    sum4 = {1'b0, ptr_q} + {1'b0, off};
    win  = (sum4 >= 4'(NREQ)) ? 3'(sum4 - 4'(NREQ)) : sum4[2:0];
  end

  // Latched winner as a one-hot mask, and the next round-robin start point.
  logic [NREQ-1:0] w_oh;
  logic            req_w;
  logic [2:0]      w_inc;

  always_comb begin
    for (int i = 0; i < NREQ; i++) w_oh[i] = (w_q == 3'(i));
    req_w = |(sreq & w_oh);
    w_inc = (w_q == 3'(NREQ-1)) ? 3'd0 : w_q + 3'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      w_q     <= 3'd0;
      cnt_q   <= 8'd0;
      br_q    <= 1'b1;
      bgack_q <= 1'b1;
      gnt_q   <= '1;
      owner_q <= 3'd0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bgack_q <= bgack_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bgack_d = bgack_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|sreq) begin
          w_d     = win;
          br_d    = 1'b0;
          cnt_d   = 8'd0;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        // Withdrawal beats a simultaneous BG so a master that left is never granted.
        if (!req_w) begin
          br_d    = 1'b1;
          state_d = IDLE;
        end else if (sbg) begin
          state_d = WAIT_BUS;
        end else if (cnt_q == 8'(TIMEOUT-1)) begin
          br_d    = 1'b1;
          tmo_d   = 1'b1;
          ptr_d   = w_inc;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_BUS: begin
        // Take the bus only once the CPU's current cycle has finished.
        if (!sas) begin
          bgack_d = 1'b0;
          br_d    = 1'b1;
          gnt_d   = ~w_oh;
          owner_d = w_q;
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_w) begin
          gnt_d   = '1;
          bgack_d = 1'b1;
          busy_d  = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        ptr_d   = w_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign BR_n    = br_q;
  assign BGACK_n = bgack_q;
  assign GNT_n   = gnt_q;
  assign OWNER   = owner_q;
  assign BUSY    = busy_q;
  assign TMO     = tmo_q;

endmodule

// File: tb/tb_sun2_dvma_arbiter.sv
// Bench for sun2_dvma_arbiter: directed handshake scenarios followed by random
// request/BG/AS traffic, every cycle compared with a behavioural model.
module tb_sun2_dvma_arbiter;
  localparam int NREQ = 4;
  localparam int SYNC = 2;
  localparam int TOUT = 8;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [NREQ-1:0] REQ_n;
  logic            BG_n, AS_n;
  logic            BR_n, BGACK_n, BUSY, TMO;
  logic [NREQ-1:0] GNT_n;
  logic [2:0]      OWNER;

  sun2_dvma_arbiter #(.NREQ(NREQ), .SYNC_STAGES(SYNC), .TIMEOUT(TOUT)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_n(REQ_n), .BG_n(BG_n), .AS_n(AS_n),
    .BR_n(BR_n), .BGACK_n(BGACK_n), .GNT_n(GNT_n), .OWNER(OWNER),
    .BUSY(BUSY), .TMO(TMO)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Reference model: pins delayed by SYNC edges, then a transaction view of the
  // bus (who is wanted, whether we wait for BG, for AS, hold, or cool down).
  logic [NREQ-1:0] h_req [SYNC];
  logic            h_bg [SYNC];
  logic            h_as [SYNC];
  bit              want_bg, want_as, holding, cooling;
  int              who, ptr, waited;
  logic            m_br, m_bgack, m_busy, m_tmo;
  logic [NREQ-1:0] m_gnt;
  logic [2:0]      m_owner;

  task automatic model_edge();
    logic [NREQ-1:0] sreq;
    logic sbg, sas;
    int pick;
    sreq = ~h_req[SYNC-1];
    sbg  = ~h_bg[SYNC-1];
    sas  = ~h_as[SYNC-1];
    if (RESET) begin
      for (int i = 0; i < SYNC; i++) begin
        h_req[i] = '1; h_bg[i] = 1'b1; h_as[i] = 1'b1;
      end
      want_bg = 0; want_as = 0; holding = 0; cooling = 0;
      who = 0; ptr = 0; waited = 0;
      m_br = 1; m_bgack = 1; m_busy = 0; m_tmo = 0; m_gnt = '1; m_owner = 0;
      return;
    end
    m_tmo = 0;
    if (cooling) begin
      ptr = (who + 1) % NREQ;
      cooling = 0;
    end else if (holding) begin
      if (!sreq[who]) begin
        m_gnt = '1; m_bgack = 1; m_busy = 0; holding = 0; cooling = 1;
      end
    end else if (want_as) begin
      if (!sas) begin
        m_bgack = 0; m_br = 1; m_gnt = '1; m_gnt[who] = 1'b0;
        m_owner = 3'(who); m_busy = 1; want_as = 0; holding = 1;
      end
    end else if (want_bg) begin
      if (!sreq[who]) begin
        m_br = 1; want_bg = 0;
      end else if (sbg) begin
        want_bg = 0; want_as = 1;
      end else if (waited == TOUT - 1) begin
        m_br = 1; m_tmo = 1; ptr = (who + 1) % NREQ; want_bg = 0;
      end else begin
        waited++;
      end
    end else begin
      pick = -1;
      for (int i = 0; i < NREQ; i++)
        if (pick < 0 && sreq[(ptr + i) % NREQ]) pick = (ptr + i) % NREQ;
      if (pick >= 0) begin
        who = pick; m_br = 0; waited = 0; want_bg = 1;
      end
    end
    for (int i = SYNC - 1; i > 0; i--) begin
      h_req[i] = h_req[i-1]; h_bg[i] = h_bg[i-1]; h_as[i] = h_as[i-1];
    end
    h_req[0] = REQ_n; h_bg[0] = BG_n; h_as[0] = AS_n;
  endtask

  task automatic compare_all();
    int lows;
    check("BR_n", BR_n, m_br);
    check("BGACK_n", BGACK_n, m_bgack);
    check("GNT_n", GNT_n, m_gnt);
    check("OWNER", OWNER, m_owner);
    check("BUSY", BUSY, m_busy);
    check("TMO", TMO, m_tmo);
    lows = 0;
    for (int i = 0; i < NREQ; i++) if (!GNT_n[i]) lows++;
    check("inv_onehot", lows <= 1, 1);
    check("inv_gnt_bgack", (lows > 0) && BGACK_n, 0);
    check("inv_br_bgack", !BR_n && !BGACK_n, 0);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int k = 0;
    while (BUSY !== v && k < 60) begin step(); k++; end
    check(tag, BUSY, v);
  endtask

  task automatic do_reset();
    RESET = 1; run(2); RESET = 0;
  endtask

  initial begin
    int k, gap;
    int seq [5] = '{0, 1, 2, 3, 0};
    bit tmo_seen;
    RESET = 1; REQ_n = '1; BG_n = 1; AS_n = 1;
    for (int i = 0; i < SYNC; i++) begin h_req[i] = '1; h_bg[i] = 1; h_as[i] = 1; end
    do_reset();
    check("rst_gnt", GNT_n, 4'hF);
    check("rst_br", BR_n, 1);

    // Single master: request latency, grant, release latency.
    REQ_n = 4'b1110;
    k = 0;
    do begin step(); k++; end while (BR_n !== 1'b0 && k < 20);
    check("br_latency", k, SYNC + 1);
    BG_n = 0;
    k = 0;
    while (BGACK_n !== 1'b0 && k < 20) begin step(); k++; end
    check("first_gnt", GNT_n, 4'b1110);
    check("first_owner", OWNER, 0);
    check("first_br", BR_n, 1);
    REQ_n = 4'b1111;
    k = 0;
    do begin step(); k++; end while (GNT_n !== 4'hF && k < 20);
    check("release_latency", k, SYNC + 1);
    check("release_bgack", BGACK_n, 1);
    BG_n = 1; run(3);

    // Round robin with everyone requesting.
    do_reset();
    REQ_n = 4'b0000; BG_n = 0; AS_n = 1;
    for (int g = 0; g < 5; g++) begin
      gap = 0;
      k = 0;
      while (BUSY !== 1'b1 && k < 60) begin step(); k++; if (BGACK_n) gap++; end
      check("rr_busy", BUSY, 1);
      check("rr_owner", OWNER, seq[g]);
      if (g > 0) check("rr_gap", gap >= 1, 1);
      REQ_n[OWNER[1:0]] = 1'b1;
      wait_busy(0, "rr_release");
      REQ_n = 4'b0000;
    end
    REQ_n = '1; BG_n = 1; run(6);

    // AS held low keeps the arbiter in the bus-wait phase.
    do_reset();
    REQ_n = 4'b1101; BG_n = 0; AS_n = 0;
    run(10);
    check("as_hold_br", BR_n, 0);
    check("as_hold_gnt", GNT_n, 4'hF);
    AS_n = 1;
    k = 0;
    do begin step(); k++; end while (GNT_n === 4'hF && k < 20);
    check("as_grant_latency", k, SYNC + 1);
    check("as_grant", GNT_n, 4'b1101);
    REQ_n = '1; BG_n = 1; run(6);

    // Timeout with BG never arriving; pointer moves past the abandoned master.
    do_reset();
    REQ_n = 4'b0011;
    k = 0;
    while (BR_n !== 1'b0 && k < 20) begin step(); k++; end
    k = 0;
    do begin step(); k++; end while (TMO !== 1'b1 && k < 40);
    check("tmo_cycles", k, TOUT);
    check("tmo_br", BR_n, 1);
    step();
    check("tmo_pulse", TMO, 0);
    BG_n = 0;
    wait_busy(1, "tmo_regrant");
    check("tmo_next_owner", OWNER, 3);
    REQ_n = '1; BG_n = 1; run(6);

    // Withdrawal before BG leaves the pointer alone.
    do_reset();
    REQ_n = 4'b1101;
    k = 0;
    while (BR_n !== 1'b0 && k < 20) begin step(); k++; end
    REQ_n = '1;
    tmo_seen = 0;
    for (int i = 0; i < 6; i++) begin step(); if (TMO) tmo_seen = 1; end
    check("wd_br", BR_n, 1);
    check("wd_no_tmo", tmo_seen, 0);
    REQ_n = 4'b1001; BG_n = 0;
    wait_busy(1, "wd_regrant");
    check("wd_owner", OWNER, 1);
    REQ_n = '1; BG_n = 1; run(6);

    // Reset during a grant drops everything and restarts arbitration at 0.
    do_reset();
    REQ_n = 4'b1101; BG_n = 0;
    wait_busy(1, "rg_first");
    REQ_n = '1;
    wait_busy(0, "rg_first_rel");
    run(3);
    REQ_n = 4'b1011;
    wait_busy(1, "rg_second");
    check("rg_owner2", OWNER, 2);
    REQ_n = 4'b1010;
    RESET = 1; step(); RESET = 0;
    check("rg_gnt", GNT_n, 4'hF);
    check("rg_bgack", BGACK_n, 1);
    check("rg_br", BR_n, 1);
    check("rg_busy", BUSY, 0);
    wait_busy(1, "rg_restart");
    check("rg_owner0", OWNER, 0);
    REQ_n = '1; BG_n = 1; run(6);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      RESET = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (REQ_n[i] && $urandom_range(0, 9) == 0) REQ_n[i] = 1'b0;
        else if (!REQ_n[i] && $urandom_range(0, 15) == 0) REQ_n[i] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) BG_n = ~BG_n;
      if ($urandom_range(0, 2) == 0) AS_n = ~AS_n;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sun2_dvma_arbiter.md
Name: sun2_dvma_arbiter

Overview:
Bus-ownership controller between the 68010 CPU and up to NREQ DVMA masters. It synchronizes asynchronous active-low requests through flip-flop chains and runs the 68000 BR/BG/BGACK handshake with the CPU. It grants the bus to one master at a time with round-robin priority. It sits between the CPU bus-control pins and the DVMA/Multibus request logic.

Parameters:
NREQ, 4, number of DVMA requesters (2..8)
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (REQ_n, BG_n, AS_n)
TIMEOUT, 255, max cycles in REQUEST waiting for BG before abandoning (1..255)

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
REQ_n  input  NREQ  asynchronous active-low bus requests, one per master; held low until the master is done
BG_n  input  1  CPU bus grant, asynchronous, active low
AS_n  input  1  CPU address strobe, asynchronous, active low
BR_n  output  1  bus request to CPU, active low, registered
BGACK_n  output  1  bus-grant-acknowledge to CPU, active low, registered
GNT_n  output  NREQ  one-hot active-low grant to masters, registered
OWNER  output  3  index of granted master; valid while BUSY=1
BUSY  output  1  high while any GNT_n is low
TMO  output  1  one-cycle pulse on request timeout

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - BR_n=1, BGACK_n=1, GNT_n=all 1, OWNER=0, BUSY=0, TMO=0.
  - Round-robin pointer PTR=0, state=IDLE, timeout counter=0.
  - All synchronizer flops preset to 1 (inactive).
  - Reset asserted in any state returns to IDLE on that edge and drops all grants immediately.
- Synchronizers: each async input passes through SYNC_STAGES flops. sREQ, sBG and sAS denote the synchronized, active-high-asserted values. All FSM decisions use synchronized values only.
- Winner selection: the first index with sREQ set, searching PTR, PTR+1, … NREQ-1, 0, … PTR-1 (wrap-around). Evaluated only in IDLE and latched as W.
- IDLE:
  - Outputs are inactive.
  - If any sREQ is set: latch W, set BR_n=0 on the same edge, clear the counter, go to REQUEST.
  - Latency: REQ_n low before edge k gives BR_n low after edge k+SYNC_STAGES.
- REQUEST: BR_n=0; counter increments each cycle. Checked in priority order:
  - (a) sREQ[W] cleared: BR_n=1, go to IDLE, PTR unchanged.
  - (b) sBG set: go to WAIT_BUS.
  - (c) counter==TIMEOUT-1: BR_n=1, TMO=1 for one cycle, PTR=W+1 mod NREQ, go to IDLE.
- WAIT_BUS: BR_n stays 0. Wait until sAS is clear, meaning the CPU cycle has ended. On that edge:
  - BGACK_n=0, BR_n=1, GNT_n[W]=0, OWNER=W, BUSY=1.
  - Go to GRANT.
  - If sREQ[W] clears while in WAIT_BUS, the grant still proceeds and is released one cycle later from GRANT.
- GRANT: hold BGACK_n=0 and GNT_n[W]=0. When sREQ[W] clears: GNT_n=all 1, BGACK_n=1, BUSY=0, go to RELEASE. Other requests are ignored while in GRANT.
- RELEASE: one idle cycle. PTR=W+1 mod NREQ. Go to IDLE. Minimum of one cycle with BGACK_n=1 between consecutive grants.
- Invariants:
  - At most one GNT_n low at any time.
  - GNT_n[i]=0 implies BGACK_n=0.
  - BR_n and BGACK_n are never both low after the grant edge.
  - OWNER holds its value after release until the next grant.
- Simultaneous events:
  - Several requests arriving on the same cycle: resolved by PTR order.
  - In REQUEST, sBG and sREQ[W] clearing on the same edge: withdrawal (a) wins.
- Counter width: 8 bits, no wrap beyond TIMEOUT.

Test Plan:
- Reset, then REQ_n=4'b1110 held: BR_n low 3 cycles after the first edge sampling REQ_n low (SYNC_STAGES=2). Drive BG_n low with AS_n high: BGACK_n=0, GNT_n=4'b1110, OWNER=0, BR_n=1. Release REQ_n[0]: GNT_n=4'b1111 and BGACK_n=1 after 3 edges.
- Round robin: REQ_n=4'b0000 held with BG_n tied low and AS_n high. Grants occur in order 0,1,2,3,0, with each master dropping its request for one grant. Each grant is separated by at least one cycle with BGACK_n=1.
- AS_n held low after BG_n asserts: the FSM stays in WAIT_BUS with BR_n=0 and GNT_n all 1. Raise AS_n: the grant appears 3 edges later.
- Timeout: TIMEOUT=8, BG_n held high, REQ_n[2]=0. After 8 cycles in REQUEST: TMO pulses for 1 cycle, BR_n=1, PTR=3. The next pending request re-arbitrates starting from index 3.
- Request withdrawn in REQUEST before BG: BR_n returns to 1 and TMO stays 0. A later request from the same master is still granted first (PTR unchanged).
- RESET asserted during GRANT: the next edge gives GNT_n=all 1, BGACK_n=1, BR_n=1, BUSY=0, PTR=0. With requests still low, arbitration restarts from index 0.
